// File: rtl/crc_pkg.sv
// Shared CRC definitions for the serial frame generator, verifier and receiver.
// crc_step works on a CRC_MAX_W-wide container, and callers pass the real width.
package crc_pkg;

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_CRC} state_t;

   localparam int CRC_MAX_W = 32;

   // One MSB-first LFSR step with no reflection. Bits above 'width' are forced to zero.
   function automatic logic [CRC_MAX_W-1:0] crc_step(
      input logic [CRC_MAX_W-1:0] crc,
      input logic                 b,
      input logic [CRC_MAX_W-1:0] poly,
      input int                   width
   );
      logic [CRC_MAX_W-1:0] top;
      logic [CRC_MAX_W-1:0] mask;
      logic                 fb;
      top  = CRC_MAX_W'(1) << (width - 1);
      mask = (CRC_MAX_W'(1) << width) - CRC_MAX_W'(1);
      fb   = b ^ (|(crc & top));
      return ((crc << 1) ^ (fb ? poly : '0)) & mask;
   endfunction

endpackage

// File: rtl/crc_frame_rx_outreg.sv
// One-deep valid/ready holding register for completed frames.
// A load made while the register is full and not draining is dropped and flagged.
module crc_frame_rx_outreg #(
   parameter int DATA_WIDTH = 12,
   parameter int CRC_WIDTH  = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic [DATA_WIDTH-1:0] load_data,
   input  logic [CRC_WIDTH-1:0]  load_crc_rx,
   input  logic [CRC_WIDTH-1:0]  load_crc_calc,
   input  logic                  load_crc_ok,
   input  logic                  out_ready,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic [CRC_WIDTH-1:0]  crc_rx,
   output logic [CRC_WIDTH-1:0]  crc_calc,
   output logic                  crc_ok,
   output logic                  frame_dropped
);

   logic accept;

   // A frame may land in the same cycle that the consumer drains the previous one.
   assign accept = load && (!out_valid || out_ready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid     <= 1'b0;
         data_out      <= '0;
         crc_rx        <= '0;
         crc_calc      <= '0;
         crc_ok        <= 1'b0;
         frame_dropped <= 1'b0;
      end else begin
         frame_dropped <= load && !accept;
         if (accept) begin
            out_valid <= 1'b1;
            data_out  <= load_data;
            crc_rx    <= load_crc_rx;
            crc_calc  <= load_crc_calc;
            crc_ok    <= load_crc_ok;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/crc_frame_rx.sv
// Bit-serial frame receiver: deserialises an MSB-first payload plus CRC field,
// checks the CRC on the fly, and hands complete frames to a one-deep output register.
module crc_frame_rx
   import crc_pkg::*;
#(
   parameter int                   DATA_WIDTH = 12,
   parameter int                   CRC_WIDTH  = 4,
   parameter logic [CRC_WIDTH:0]   POLY       = 5'b10011,
   parameter logic [CRC_WIDTH-1:0] SEED       = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  bit_valid,
   input  logic                  bit_in,
   input  logic                  frame_start,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic [CRC_WIDTH-1:0]  crc_rx,
   output logic [CRC_WIDTH-1:0]  crc_calc,
   output logic                  crc_ok,
   output logic                  frame_dropped,
   output logic                  frame_abort
);

   localparam int CNT_MAX = (DATA_WIDTH > CRC_WIDTH) ? DATA_WIDTH : CRC_WIDTH;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
   localparam logic [CNT_W-1:0] CRC_CNT   = CNT_W'(CRC_WIDTH);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CRC_MAX_W-1:0] POLY_X = CRC_MAX_W'(POLY[CRC_WIDTH-1:0]);

   state_t                state, state_nxt;
   logic [CNT_W-1:0]      cnt, cnt_nxt;
   logic [CRC_WIDTH-1:0]  crc_reg, crc_nxt;
   logic [CRC_WIDTH-1:0]  crc_seed_step, crc_bit_step;
   logic [DATA_WIDTH-1:0] data_sh, data_nxt, data_shifted;
   logic [CRC_WIDTH-1:0]  crc_sh, crc_sh_nxt, crc_field;
   logic                  restart, frame_done, abort_c, abort_q, crc_match;

   assign restart       = bit_valid && frame_start;
   assign crc_seed_step = CRC_WIDTH'(crc_step(CRC_MAX_W'(SEED), bit_in, POLY_X, CRC_WIDTH));
   assign crc_bit_step  = CRC_WIDTH'(crc_step(CRC_MAX_W'(crc_reg), bit_in, POLY_X, CRC_WIDTH));
   assign data_shifted  = (data_sh << 1) | DATA_WIDTH'(bit_in);
   // The full received field includes the bit being sampled right now.
   assign crc_field     = (crc_sh << 1) | CRC_WIDTH'(bit_in);
   assign crc_match     = (crc_field == crc_reg);

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      crc_nxt    = crc_reg;
      data_nxt   = data_sh;
      crc_sh_nxt = crc_sh;
      frame_done = 1'b0;
      abort_c    = 1'b0;
      if (restart) begin
         // A start bit always begins a new frame, even if another frame is still in progress.
         abort_c  = (state != S_IDLE);
         crc_nxt  = crc_seed_step;
         data_nxt = DATA_WIDTH'(bit_in);
         if (DATA_WIDTH == 1) begin
            state_nxt = S_CRC;
            cnt_nxt   = CRC_CNT;
         end else begin
            state_nxt = S_DATA;
            cnt_nxt   = DATA_LAST;
         end
      end else if (bit_valid) begin
         case (state)
            S_DATA: begin
               data_nxt = data_shifted;
               crc_nxt  = crc_bit_step;
               cnt_nxt  = cnt - CNT_ONE;
               if (cnt == CNT_ONE) begin
                  state_nxt = S_CRC;
                  cnt_nxt   = CRC_CNT;
               end
            end
            S_CRC: begin
               crc_sh_nxt = crc_field;
               cnt_nxt    = cnt - CNT_ONE;
               if (cnt == CNT_ONE) begin
                  frame_done = 1'b1;
                  state_nxt  = S_IDLE;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         cnt     <= '0;
         crc_reg <= SEED;
         data_sh <= '0;
         crc_sh  <= '0;
         abort_q <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         crc_reg <= crc_nxt;
         data_sh <= data_nxt;
         crc_sh  <= crc_sh_nxt;
         abort_q <= abort_c;
      end
   end

   assign frame_abort = abort_q;

   crc_frame_rx_outreg #(
      .DATA_WIDTH(DATA_WIDTH),
      .CRC_WIDTH (CRC_WIDTH)
   ) u_outreg (
      .clk          (clk),
      .rst_n        (rst_n),
      .load         (frame_done),
      .load_data    (data_sh),
      .load_crc_rx  (crc_field),
      .load_crc_calc(crc_reg),
      .load_crc_ok  (crc_match),
      .out_ready    (out_ready),
      .out_valid    (out_valid),
      .data_out     (data_out),
      .crc_rx       (crc_rx),
      .crc_calc     (crc_calc),
      .crc_ok       (crc_ok),
      .frame_dropped(frame_dropped)
   );

endmodule

// File: doc/crc_frame_rx.md
Name: crc_frame_rx

Overview:
- Bit-serial frame receiver and CRC checker. It is the far end of a serial link whose transmitter sends DATA_WIDTH payload bits MSB-first, followed by CRC_WIDTH CRC bits MSB-first.
- Deserialises the payload and computes its CRC on the fly, one bit per accepted cycle. It then compares the computed CRC against the received CRC field.
- Presents each completed frame on a one-deep valid/ready output register, together with a pass/fail flag. Sits between the PHY bit sampler and the FEC decode path.

Parameters:
- DATA_WIDTH, 12: payload bits per frame (>=1).
- CRC_WIDTH, 4: CRC bits per frame (>=1).
- POLY, 5'b10011: generator polynomial, CRC_WIDTH+1 bits, MSB implicit.
- SEED, '0: CRC register value loaded at frame start.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: asynchronous active-low reset.
- bit_valid, input, 1: bit_in is valid this cycle.
- bit_in, input, 1: serial data bit.
- frame_start, input, 1: qualified by bit_valid; marks the current bit as the first payload bit.
- out_valid, output, 1: frame available.
- out_ready, input, 1: consumer accepts the frame when out_valid && out_ready.
- data_out, output, DATA_WIDTH: received payload.
- crc_rx, output, CRC_WIDTH: received CRC field.
- crc_calc, output, CRC_WIDTH: locally computed CRC.
- crc_ok, output, 1: crc_rx == crc_calc.
- frame_dropped, output, 1: one-cycle pulse; a completed frame was discarded because the output register was occupied.
- frame_abort, output, 1: one-cycle pulse; frame_start arrived mid-frame.

Behaviour:
- Reset: all outputs 0, state S_IDLE, counters 0, CRC register = SEED. Reset is asynchronous, may occur at any time, and discards any partial or held frame.
- CRC step, per bit b: fb = b ^ crc[CRC_WIDTH-1]; crc = (crc << 1) ^ (fb ? POLY[CRC_WIDTH-1:0] : 0).
  - MSB-first, no reflection, no final XOR.
  - Applied to payload bits only. CRC-field bits are shifted into a separate register, not into the CRC register.
- Only cycles with bit_valid=1 advance the receiver. Cycles with bit_valid=0 hold all state.
- States:
  - S_IDLE: wait for bit_valid && frame_start. On that bit: crc = step(SEED, bit_in), payload shift = bit_in, cnt = DATA_WIDTH-1. Go to S_DATA, or to S_CRC if DATA_WIDTH==1.
  - S_DATA: each valid bit shifts into the payload register and steps the CRC; cnt decrements. The bit that brings cnt to 0 moves the block to S_CRC with cnt = CRC_WIDTH.
  - S_CRC: each valid bit shifts into the crc_rx shift register; cnt decrements. On the last CRC bit, the frame completes and the block returns to S_IDLE.
- Completion, on the clock edge sampling the last CRC bit:
  - If the output register is empty, or being drained this cycle (out_valid && out_ready), load data_out, crc_rx, crc_calc and crc_ok, and set out_valid=1.
  - Otherwise discard the frame, leave the output registers unchanged, and pulse frame_dropped on the next cycle.
- Latency: out_valid is high in the cycle after the last CRC bit is sampled.
- Output register: out_valid stays high and the outputs are stable until out_ready. It clears on acceptance unless a new frame is loaded in the same cycle, in which case out_valid stays 1 and the new frame's values appear.
- The receiver keeps accepting bits while out_valid is held; back-to-back frames with zero idle bits are supported.
- frame_start with bit_valid in S_DATA or S_CRC:
  - Abort the current frame and pulse frame_abort on the next cycle.
  - Restart exactly as from S_IDLE using the current bit.
  - The output register is unaffected.
- frame_start on the last CRC bit is an abort of the completing frame plus a restart; no output is loaded for the aborted frame.
- frame_start while bit_valid=0 is ignored.
- Counter width: $clog2(max(DATA_WIDTH, CRC_WIDTH)+1) bits.
- crc_ok is computed combinationally from the final CRC register and {crc_rx_shift, bit_in}, then registered into the output.

Decomposition:
- Package crc_pkg: the state_t enum (S_IDLE, S_DATA, S_CRC), and a function crc_step(crc, bit, poly) parameterised by width. The same function is to be adopted by the generator and verifier blocks.
- One natural sub-module, crc_frame_rx_outreg: the one-deep valid/ready holding register with load/drain/drop arbitration. The top level holds the FSM, counters, shift registers and CRC.

Test Plan:
- Defaults, payload 0xABC, CRC field 0xA, continuous bit_valid -> 16 cycles later out_valid=1, data_out=0xABC, crc_calc=0xA, crc_rx=0xA, crc_ok=1.
- Same payload with CRC field 0xB -> crc_ok=0, crc_rx=0xB, crc_calc=0xA; no drop or abort pulses.
- Frame 0xABC/0xA sent with bit_valid toggling 1,0,1,0... -> identical outputs, out_valid one cycle after the 16th valid bit.
- Two back-to-back good frames with out_ready held 0 -> first frame held on the outputs, frame_dropped pulses once after the second frame's last bit. out_ready=1 then drains the first frame and out_valid clears.
- frame_start asserted on payload bit 7, followed by a full 0xABC/0xA frame -> frame_abort pulses once, then a single output with crc_ok=1.
- rst_n pulsed low mid-CRC-field while out_valid=1 -> all outputs 0 immediately. A following good frame is received normally with crc_ok=1.
